// File: rtl/mips_bus_mem_responder_pkg.sv
// rtl/mips_bus_mem_responder_pkg.sv - shared types and constants for the bus memory responder
package mips_bus_pkg;

  // Responder transfer phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } bus_state_t;

  localparam int BYTE_LANES = 4;

  // x^8 + x^6 + x^5 + x^4 + 1 as a left-shifting Fibonacci register: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

endpackage

// File: rtl/mips_bus_mem_responder_if.sv
// rtl/mips_bus_mem_responder_if.sv - Avalon-style CPU bus between master and memory responder
interface mips_bus_if
  import mips_bus_pkg::*;
;
  logic [31:0]           address;
  logic                  read;
  logic                  write;
  logic [31:0]           writedata;
  logic [BYTE_LANES-1:0] byteenable;
  logic                  waitrequest;
  logic [31:0]           readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_bus_mem_responder_lfsr.sv
// rtl/mips_bus_mem_responder_lfsr.sv - 8-bit LFSR supplying pseudo-random wait-state counts
module bus_wait_lfsr
  import mips_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  // Shift left once per accepted request, feeding back the parity of the tapped bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mips_bus_mem_responder.sv
// rtl/mips_bus_mem_responder.sv - word RAM slave for the CPU bus with wait states and misuse flags
module mips_bus_mem_responder
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter bit          RANDOM_WAIT = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  mips_bus_if.slave bus,
  output logic     range_error,
  output logic     protocol_error
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(MEM_WORDS) << 2;

  bus_state_t state, state_next;

  logic [31:0]           mem [MEM_WORDS];
  logic [3:0]            cnt;
  logic [31:0]           lat_addr;
  logic                  lat_read;
  logic                  lat_write;
  logic [31:0]           lat_wdata;
  logic [BYTE_LANES-1:0] lat_be;
  logic [31:0]           readdata_q;
  logic [7:0]            lfsr_value;

  logic                  req;
  logic                  accept;
  logic                  abort;
  logic                  enter_ack;
  logic                  commit;
  logic                  waitrequest;
  logic [3:0]            load_n;

  // The live bus is decoded in IDLE; once a request is taken only the latched copy matters
  logic [31:0]           cur_addr;
  logic                  cur_read;
  logic                  cur_write;
  logic [31:0]           offset;
  logic                  cur_in_range;
  logic [IDX_W-1:0]      cur_idx;

  assign req          = bus.read | bus.write;
  assign cur_addr     = (state == IDLE) ? bus.address : lat_addr;
  assign cur_read     = (state == IDLE) ? bus.read    : lat_read;
  assign cur_write    = (state == IDLE) ? bus.write   : lat_write;
  assign offset       = cur_addr - BASE_ADDR;
  assign cur_in_range = offset < SPAN;
  assign cur_idx      = offset[IDX_W+1:2];

  assign bus.waitrequest = waitrequest;
  assign bus.readdata    = readdata_q;

  bus_wait_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr_value)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-phase control strobes
  always_comb begin
    state_next  = state;
    waitrequest = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    enter_ack   = 1'b0;
    commit      = 1'b0;
    load_n      = RANDOM_WAIT ? 4'(lfsr_value & 8'h03) : 4'(WAIT_CYCLES);
    case (state)
      IDLE: begin
        waitrequest = req;
        if (req) begin
          accept = 1'b1;
          if (load_n == 4'd0) begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        waitrequest = 1'b1;
        if ((bus.read != lat_read) || (bus.write != lat_write)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (cnt == 4'd1) begin
          state_next = ACK;
          enter_ack  = 1'b1;
        end
      end
      ACK: begin
        commit     = lat_write & ~lat_read & cur_in_range;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter, read data and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= 4'd0;
      lat_addr       <= 32'd0;
      lat_read       <= 1'b0;
      lat_write      <= 1'b0;
      lat_wdata      <= 32'd0;
      lat_be         <= '0;
      readdata_q     <= 32'd0;
      range_error    <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr  <= bus.address;
        lat_read  <= bus.read;
        lat_write <= bus.write;
        lat_wdata <= bus.writedata;
        lat_be    <= bus.byteenable;
        cnt       <= load_n;
        if (!cur_in_range) begin
          range_error <= 1'b1;
        end
        if (bus.read && bus.write) begin
          protocol_error <= 1'b1;
        end
      end else if (abort) begin
        cnt            <= 4'd0;
        protocol_error <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_ack) begin
        readdata_q <= (cur_read && !cur_write && cur_in_range) ? mem[cur_idx] : 32'd0;
      end
    end
  end

  // Memory write on the ACK edge, one byte lane at a time; contents are never reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (lat_be[i]) begin
          mem[cur_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
